// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, valid/ready handshake on both operand and result sides.
module seq_divider #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] x,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           ovf,
    output logic           dz
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_r;
    logic            r_ovf;
    logic            r_dz;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    r_div;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;

    logic [W-1:0]    w_hi;
    logic [2*W-1:0]  w_step;
    logic            w_accept;

    // One restoring step: returns {next partial remainder, next quotient}.
    // The subtraction is done in W bits because the true result is always < div.
    function automatic logic [2*W-1:0] div_step(
        input logic [W-1:0] rem,
        input logic [W-1:0] quo,
        input logic [W-1:0] div
    );
        logic [W:0] t;
        logic       ge;
        t  = {rem, quo[W-1]};
        ge = (t >= {1'b0, div});
        div_step = {(ge ? (t[W-1:0] - div) : t[W-1:0]), quo[W-2:0], ge};
    endfunction

    assign w_hi     = x[2*W-1:W];
    assign w_step   = div_step(r_rem, r_quo, r_div);
    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (y == '0) begin
                            r_dz        <= 1'b1;
                            r_ovf       <= 1'b1;
                            r_q         <= '1;
                            r_r         <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_hi >= y) begin
                            r_dz        <= 1'b0;
                            r_ovf       <= 1'b1;
                            r_q         <= '1;
                            r_r         <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_cnt   <= CW'(W - 1);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        r_q         <= w_step[W-1:0];
                        r_r         <= w_step[2*W-1:W];
                        r_ovf       <= 1'b0;
                        r_dz        <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_div <= y;
            r_rem <= w_hi;
            r_quo <= x[W-1:0];
        end else if (r_state == RUN) begin
            r_rem <= w_step[2*W-1:W];
            r_quo <= w_step[W-1:0];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign r         = r_r;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive bench for seq_divider (W=4) with a result scoreboard.
module tb_seq_divider;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] x;
        logic [W-1:0]   y;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           ovf;
        logic           dz;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] x;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dz;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2*W-1:0] xv, input logic [W-1:0] yv);
        exp_t e;
        int   qi;
        e.x = xv;
        e.y = yv;
        if (yv == 0) begin
            e.q = '1; e.r = '0; e.ovf = 1'b1; e.dz = 1'b1;
        end else begin
            qi = int'(xv) / int'(yv);
            if (qi > (1 << W) - 1) begin
                e.q = '1; e.r = '0; e.ovf = 1'b1; e.dz = 1'b0;
            end else begin
                e.q = W'(qi);
                e.r = W'(int'(xv) % int'(yv));
                e.ovf = 1'b0; e.dz = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard: compare every accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("result_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("q", 64'(q), 64'(e.q));
                check("r", 64'(r), 64'(e.r));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("dz", 64'(dz), 64'(e.dz));
                if (!e.ovf) begin
                    check("x_eq_qy_plus_r", 64'(int'(q) * int'(e.y) + int'(r)), 64'(e.x));
                    check("r_lt_y", 64'(r < e.y), 64'd1);
                end
            end
        end
    end

    task automatic do_div(input logic [2*W-1:0] xv, input logic [W-1:0] yv, input int stall);
        exp_t e;
        int   n;
        int   lat;
        e = model(xv, yv);
        sb.push_back(e);
        in_valid  = 1'b1;
        x         = xv;
        y         = yv;
        out_ready = (stall == 0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = (2*W)'($urandom);
        y = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        check("latency", 64'(lat), e.ovf ? 64'd1 : 64'(W + 1));
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_div(8'h8F, 4'd13, 0);
        do_div(8'd100, 4'd7, 0);
        do_div(8'd225, 4'd15, 0);
        do_div(8'd200, 4'd12, 0);
        do_div(8'd37, 4'd0, 0);

        // Back-pressure with operands pending the whole time.
        sb.push_back(model(8'd100, 4'd7));
        in_valid  = 1'b1;
        x         = 8'd100;
        y         = 4'd7;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        x = 8'd50;
        y = 4'd4;
        sb.push_back(model(8'd50, 4'd4));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("bp_in_ready_busy", 64'(in_ready), 64'd0);
        end while (!out_valid && lat < 50);
        check("bp_latency", 64'(lat), 64'(W + 1));
        for (int i = 0; i < 6; i++) begin
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_q_hold", 64'(q), 64'd14);
            check("bp_r_hold", 64'(r), 64'd2);
            check("bp_in_ready_hold", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_accept", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_out_valid_after", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        check("bp_second_latency", 64'(lat), 64'(W + 1));
        @(posedge clk); #1;

        // Reset in the second RUN cycle discards the division in flight.
        in_valid = 1'b1;
        x = 8'd143;
        y = 4'd13;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_q", 64'(q), 64'd0);
        check("mid_rst_r", 64'(r), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        check("mid_rst_dz", 64'(dz), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div(8'd100, 4'd7, 0);

        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                do_div(8'(xi), 4'(yi), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider; the inverse operation of the team's array multipliers.
- Takes a 2W-bit dividend (for example a product `o`) and a W-bit divisor. Returns a W-bit quotient and a W-bit remainder.
- Resolves one quotient bit per clock behind a valid/ready handshake on both sides.
- Used to check multiplier results and as the divide unit beside the multiplier in the arithmetic datapath.

Parameters:
- W, 4, divisor/quotient/remainder width; dividend is 2W bits. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair x, y is valid.
- in_ready  output  1  block can accept operands (IDLE only).
- x  input  2W  dividend, unsigned.
- y  input  W  divisor, unsigned.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- q  output  W  quotient.
- r  output  W  remainder.
- ovf  output  1  quotient does not fit in W bits (x[2W-1:W] >= y). Also set on divide by zero.
- dz  output  1  divide by zero (y == 0).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, q=0, r=0, ovf=0, dz=0, counter=0. Takes effect immediately, including mid-division; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready at a rising edge; capture y into the divisor register.
  - If y==0: set dz=1, ovf=1, q=all ones, r=0; go to DONE.
  - Else if x[2W-1:W] >= y: set ovf=1, dz=0, q=all ones, r=0; go to DONE.
  - Else: load partial remainder R (W+1 bits) = {0, x[2W-1:W]}, quotient shift register Q = x[W-1:0], counter = W-1; go to RUN.
- RUN (in_ready=0):
  - Each cycle: T = {R[W-1:0], Q[W-1]}.
  - If T >= {0,y}: R = T - y, Q = {Q[W-2:0],1}. Else: R = T, Q = {Q[W-2:0],0}.
  - When counter==0, the final iteration also loads q=Q', r=R'[W-1:0], ovf=0, dz=0, and the FSM goes to DONE. Otherwise counter decrements.
  - Exactly W RUN cycles.
- DONE:
  - out_valid=1; q, r, ovf, dz held stable until the handshake.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
  - in_ready returns to 1 the cycle after; there is no same-cycle accept of new operands.
- Latency (handshake edge = cycle 0):
  - Normal: out_valid=1 in cycle W+1.
  - Overflow/zero divisor: out_valid=1 in cycle 1.
  - Throughput: one division per W+2 cycles minimum.
- Operands:
  - x and y are ignored outside the IDLE accept cycle; changing them during RUN has no effect.
  - in_valid while busy is ignored and not queued.
- Outputs q, r, ovf, dz are registered and only change on the IDLE→DONE or RUN→DONE transitions.
- Arithmetic invariant on normal completion: x == q*y + r and r < y.
- out_ready held high in advance: the result is accepted in the first DONE cycle (out_valid high for exactly one cycle).
- Back-pressure: out_ready low holds DONE indefinitely; outputs must not change.

Test Plan (W=4):
- Normal divisions, out_ready=1:
  - x=0x8F (143), y=13 → q=11, r=0, ovf=0, dz=0; out_valid rises exactly 5 cycles after accept.
  - x=100, y=7 → q=14, r=2.
  - x=225, y=15 → q=15, r=0.
- Overflow: x=200 (0xC8), y=12 → ovf=1, dz=0, q=0xF, r=0; out_valid in cycle 1.
- Divide by zero: x=37, y=0 → dz=1, ovf=1, q=0xF, r=0; out_valid in cycle 1.
- Back-pressure and busy:
  - Hold out_ready=0 for 6 cycles after out_valid: q, r, out_valid stable.
  - Drive in_valid=1 with new operands throughout: in_ready stays 0 and nothing is accepted until the cycle after the out handshake.
- Reset mid-operation: assert rst_n=0 in RUN cycle 2 of x=143, y=13 → all outputs return to reset values immediately; after release, x=100, y=7 gives q=14, r=2 with no residue.
- Exhaustive random: all x in 0..255, y in 0..15 with random out_ready stalls → compare q, r, ovf, dz against a reference model; check x == q*y + r whenever ovf=0.
